// File: rtl/cmd_decoder.sv
// cmd_decoder: decodes SYNCH / REPEAT / ST framed commands and streams 4*N payload bytes
module cmd_decoder #(
  parameter logic [11:0] SYNCH_FRAME = 12'b010101010011,
  parameter logic [7:0]  OP_REPEAT   = 8'hA0,
  parameter logic [7:0]  OP_ST       = 8'h66
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [11:0] i_data,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [7:0]  o_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [7:0]  o_repeat,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [1:0]  o_err_code
);
  typedef enum logic [2:0] {IDLE, CMD, RPT_CNT, ST_WAIT, DATA} state_t;
  state_t state, state_n;
  logic [9:0] cnt, cnt_n;
  logic [7:0] rep_n, data_n, pl;
  logic [1:0] code_n;
  logic err_n, done_n, valid_n, acc, frame_ok, par_ok;
  assign pl = i_data[8:1];
  assign frame_ok = !i_data[0] && &i_data[11:10];
  assign par_ok = i_data[9] == ^pl;
  assign o_ready = !o_valid || i_ready;
  assign acc = i_valid && o_ready;
  assign o_busy = state != IDLE;
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state <= IDLE;
      cnt <= '0;
      o_repeat <= '0;
      o_data <= '0;
      o_valid <= 1'b0;
      o_done <= 1'b0;
      o_err <= 1'b0;
      o_err_code <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      o_repeat <= rep_n;
      o_data <= data_n;
      o_valid <= valid_n;
      o_done <= done_n;
      o_err <= err_n;
      o_err_code <= code_n;
    end
  end
  // a pending byte stays on o_data until consumed, even across errors
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    rep_n = o_repeat;
    data_n = o_data;
    valid_n = o_valid && !i_ready;
    done_n = 1'b0;
    err_n = 1'b0;
    code_n = o_err_code;
    if (acc) begin
      if (state == IDLE) begin
        state_n = i_data == SYNCH_FRAME ? CMD : IDLE;
        err_n = i_data != SYNCH_FRAME;
        code_n = i_data == SYNCH_FRAME ? o_err_code : 2'd0;
      end else if (!frame_ok || !par_ok) begin
        state_n = IDLE;
        err_n = 1'b1;
        code_n = frame_ok ? 2'd2 : 2'd1;
      end else begin
        case (state)
          CMD: begin
            if (pl == OP_REPEAT) state_n = RPT_CNT;
            else if (pl == OP_ST) begin
              state_n = IDLE;
              rep_n = '0;
              done_n = 1'b1;
            end else begin
              state_n = IDLE;
              err_n = 1'b1;
              code_n = 2'd3;
            end
          end
          RPT_CNT: begin
            rep_n = pl;
            state_n = ST_WAIT;
          end
          ST_WAIT: begin
            if (pl == OP_ST) begin
              cnt_n = {o_repeat, 2'b00};
              state_n = o_repeat == '0 ? IDLE : DATA;
              done_n = o_repeat == '0;
            end else begin
              state_n = IDLE;
              err_n = 1'b1;
              code_n = 2'd3;
            end
          end
          DATA: begin
            data_n = pl;
            valid_n = 1'b1;
            cnt_n = cnt - 10'd1;
            state_n = cnt == 10'd1 ? IDLE : DATA;
            done_n = cnt == 10'd1;
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cmd_decoder.sv
// tb_cmd_decoder: directed self-checking bench for cmd_decoder
module tb_cmd_decoder;
  localparam logic [11:0] SYNCH = 12'b010101010011;
  logic i_clk = 1'b0, i_rstn, i_valid, i_ready;
  logic [11:0] i_data;
  logic o_ready, o_valid, o_busy, o_done, o_err;
  logic [7:0] o_data, o_repeat;
  logic [1:0] o_err_code;
  int checks = 0, errors = 0;
  int n_done = 0, n_err = 0, n_both = 0;
  logic [7:0] rx_q[$], exp_q[$];

  cmd_decoder dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_repeat(o_repeat), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_err_code(o_err_code)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) if (i_rstn) begin
    if (o_valid && i_ready) rx_q.push_back(o_data);
    if (o_done) n_done++;
    if (o_err) n_err++;
    if (o_done && o_err) n_both++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] fr(input logic [7:0] b);
    return {2'b11, ^b, b, 1'b0};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [11:0] f);
    int n = 0;
    i_data = f;
    i_valid = 1'b1;
    @(negedge i_clk);
    while (!o_ready && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'(n), 32'(0));
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic data(input logic [7:0] b);
    exp_q.push_back(b);
    send(fr(b));
  endtask

  task automatic verify(input string tag);
    chk({tag, "_nbytes"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk({tag, "_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
    rx_q.delete();
    exp_q.delete();
    n_done = 0;
    n_err = 0;
  endtask

  task automatic header(input logic [7:0] n);
    send(SYNCH);
    send(fr(8'hA0));
    send(fr(n));
    send(fr(8'h66));
  endtask

  initial begin
    logic [7:0] b;
    i_rstn = 1'b0;
    i_valid = 1'b0;
    i_data = '0;
    i_ready = 1'b1;
    idle(3);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_data", 32'(o_data), 0);
    chk("rst_repeat", 32'(o_repeat), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_flags", {o_done, o_err, o_err_code}, 0);
    chk("rst_ready", 32'(o_ready), 1);
    i_rstn = 1'b1;
    idle(1);

    header(8'h0A);
    chk("t1_busy", 32'(o_busy), 1);
    for (int i = 0; i < 40; i++) data(8'($urandom));
    chk("t1_done_pulse", 32'(o_done), 1);
    chk("t1_idle", 32'(o_busy), 0);
    chk("t1_repeat", 32'(o_repeat), 32'h0A);
    idle(3);
    chk("t1_ndone", 32'(n_done), 1);
    chk("t1_nerr", 32'(n_err), 0);
    verify("t1");

    send(SYNCH);
    send(fr(8'h66));
    chk("t2_done_pulse", 32'(o_done), 1);
    chk("t2_repeat", 32'(o_repeat), 0);
    idle(3);
    chk("t2_ndone", 32'(n_done), 1);
    verify("t2");

    header(8'h01);
    data(8'h11);
    data(8'h22);
    i_ready = 1'b0;
    i_data = fr(8'h33);
    i_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      chk("t3_stall_ready", 32'(o_ready), 0);
      chk("t3_stall_data", 32'(o_data), 32'h22);
    end
    @(posedge i_clk);
    #1;
    i_ready = 1'b1;
    data(8'h33);
    data(8'h44);
    chk("t3_done_pulse", 32'(o_done), 1);
    idle(3);
    chk("t3_ndone", 32'(n_done), 1);
    verify("t3");

    header(8'h01);
    data(8'h5A);
    b = 8'hC3;
    send(fr(b) ^ 12'h200);
    chk("t4_err", 32'(o_err), 1);
    chk("t4_code", 32'(o_err_code), 2);
    chk("t4_busy", 32'(o_busy), 0);
    idle(4);
    chk("t4_ndone", 32'(n_done), 0);
    chk("t4_nerr", 32'(n_err), 1);
    verify("t4");

    send(SYNCH);
    send(fr(8'h55));
    chk("t5_err3", 32'(o_err), 1);
    chk("t5_code3", 32'(o_err_code), 3);
    idle(1);
    chk("t5_err_pulse", 32'(o_err), 0);
    chk("t5_code_held", 32'(o_err_code), 3);
    send(12'h000);
    chk("t5_err0", 32'(o_err), 1);
    chk("t5_code0", 32'(o_err_code), 0);
    chk("t5_busy", 32'(o_busy), 0);
    send(SYNCH);
    send(fr(8'h42) & 12'h3FF);
    chk("t5_code1", 32'(o_err_code), 1);
    idle(2);
    verify("t5");

    header(8'h02);
    data(8'h01);
    data(8'h02);
    send(fr(8'h03));
    i_ready = 1'b0;
    i_rstn = 1'b0;
    idle(1);
    chk("t6_valid", 32'(o_valid), 0);
    chk("t6_data", 32'(o_data), 0);
    chk("t6_repeat", 32'(o_repeat), 0);
    chk("t6_busy", 32'(o_busy), 0);
    chk("t6_flags", {o_done, o_err, o_err_code}, 0);
    i_rstn = 1'b1;
    i_ready = 1'b1;
    idle(2);
    verify("t6_flush");
    send(fr(8'h66));
    chk("t6_first_idle_err", 32'(o_err), 1);
    chk("t6_first_idle_code", 32'(o_err_code), 0);
    header(8'h01);
    data(8'hDE);
    data(8'hAD);
    data(8'hBE);
    data(8'hEF);
    chk("t6_done_pulse", 32'(o_done), 1);
    idle(3);
    chk("t6_ndone", 32'(n_done), 1);
    chk("t6_nerr", 32'(n_err), 1);
    verify("t6");

    chk("err_done_overlap", 32'(n_both), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cmd_decoder.md
CMD_DECODER -- requirements
Module: cmd_decoder

Interface
REQ-001 The block SHALL have the parameter SYNCH_FRAME, default 12'b010101010011, meaning the exact 12-bit SYNCH frame pattern.
REQ-002 The block SHALL have the parameter OP_REPEAT, default 8'hA0, meaning the REPEAT instruction byte.
REQ-003 The block SHALL have the parameter OP_ST, default 8'h66, meaning the ST instruction byte.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset: i_clk in 1, rising-edge clock; i_rstn in 1, synchronous active-low reset.
REQ-005 The block SHALL have the port i_data in 12, meaning the received frame: [0] start, [8:1] byte, [9] parity, [11:10] stop.
REQ-006 The block SHALL have the port i_valid in 1, meaning i_data is valid.
REQ-007 The block SHALL have the port o_ready out 1, meaning a frame can be accepted.
REQ-008 The block SHALL have the port o_data out 8, meaning the decoded payload byte.
REQ-009 The block SHALL have the port o_valid out 1, meaning o_data is valid.
REQ-010 The block SHALL have the port i_ready in 1, meaning the sink accepts o_data.
REQ-011 The block SHALL have the port o_repeat out 8, meaning the repeat count N latched for the current transaction.
REQ-012 The block SHALL have the port o_busy out 1, meaning the block is not in IDLE.
REQ-013 The block SHALL have the port o_done out 1, a one-cycle pulse at transaction completion.
REQ-014 The block SHALL have the port o_err out 1, a one-cycle pulse on a protocol error.
REQ-015 The block SHALL have the port o_err_code out 2, meaning the error cause: 0 synch, 1 frame, 2 parity, 3 cmd; held until the next error.

Function
REQ-016 Frame acceptance SHALL occur only on i_valid && o_ready at a rising edge of i_clk.
REQ-017 o_ready SHALL equal !o_valid || i_ready, so that back-pressure stalls intake.
REQ-018 A frame SHALL be well-formed iff i_data[0]==0, i_data[11:10]==2'b11 and i_data[9]==^i_data[8:1] (even parity).
REQ-019 The FSM states SHALL be IDLE, CMD, RPT_CNT, ST_WAIT and DATA.
REQ-020 IDLE: a frame equal to SYNCH_FRAME (whole-word compare, no frame check) SHALL move the FSM to CMD; any other frame SHALL be discarded with o_err pulsed and code 0, and the FSM stays in IDLE.
REQ-021 In every non-IDLE state, each accepted frame SHALL be checked: stop or start bad -> code 1; otherwise parity bad -> code 2. On either error, o_err SHALL pulse and the FSM SHALL return to IDLE.
REQ-022 CMD: byte OP_REPEAT -> RPT_CNT; byte OP_ST -> N=0, then zero-data completion; any other byte -> code 3, IDLE.
REQ-023 RPT_CNT: the byte SHALL latch into o_repeat (N), then the FSM SHALL go to ST_WAIT.
REQ-024 ST_WAIT: byte OP_ST -> load the byte counter with 4*N (10-bit, maximum 1020), then DATA, or completion if N==0; any other byte -> code 3, IDLE.
REQ-025 DATA: each accepted byte SHALL be registered into o_data, with o_valid asserted the next cycle.
REQ-026 o_valid SHALL be held until i_ready is high; o_data SHALL be stable while o_valid && !i_ready.
REQ-027 In DATA, the counter SHALL decrement per accepted byte; on the byte that takes the count to 0, the FSM SHALL go to IDLE.
REQ-028 Completion SHALL pulse o_done in the cycle after the last required frame is accepted (the ST frame when N==0).
REQ-029 o_done SHALL be independent of whether the final o_data has yet been consumed.
REQ-030 An ill-formed data frame SHALL NOT produce o_valid; any byte already pending SHALL still be delivered.
REQ-031 o_repeat SHALL retain its value until overwritten by the next RPT_CNT byte; a transaction without REPEAT SHALL set it to 0.
REQ-032 o_busy SHALL be 1 in every state except IDLE.
REQ-033 o_err and o_done SHALL never be asserted in the same cycle.

Reset
REQ-034 While i_rstn==0 at a clock edge, the FSM SHALL go to IDLE and outputs SHALL take their reset values: o_valid=0, o_data=0, o_repeat=0, o_done=0, o_err=0, o_err_code=0, o_busy=0, counter=0.
REQ-035 Reset mid-transaction SHALL discard any pending byte without delivering it.
REQ-036 After reset release, the first accepted frame SHALL be evaluated in IDLE.

Verification
REQ-037 The bench SHALL cover: SYNCH, {A0}, {0A}, {66}, 40 random bytes, i_ready=1 -> 40 o_valid beats matching in order, o_repeat=10, one o_done after the 40th frame, no o_err.
REQ-038 The bench SHALL cover: SYNCH, {66} -> o_done one cycle after the ST frame, no o_valid, o_repeat=0.
REQ-039 The bench SHALL cover: N=1 with i_ready low for 5 cycles on byte 2 -> o_ready low while stalled, o_data stable, all 4 bytes delivered exactly once.
REQ-040 The bench SHALL cover: data frame with flipped parity bit -> o_err with code 2, FSM in IDLE, no o_valid for that byte, o_done never pulses.
REQ-041 The bench SHALL cover: SYNCH then byte 8'h55 well-formed -> o_err with code 3; then frame 12'h000 in IDLE -> o_err with code 0.
REQ-042 The bench SHALL cover: i_rstn=0 asserted after 3 data bytes of N=2 -> all outputs at reset values next edge, then a new full transaction completes correctly.
